capture_trigger: RTL and testbench
==================================

Name: capture_trigger

Overview:
- Front-end stage that feeds the 64K-sample capture RAM.
- Takes the raw 10-bit ADC sample stream and applies integer decimation.
- Waits for a rising-edge level trigger.
- Then emits exactly DEPTH samples as a data/valid stream (signal_out/mem_valid) for the downstream RAM writer, and reports completion.

Parameters:
DATA_W, 10, sample width.
DEPTH, 65536, samples emitted per capture; must match the downstream RAM depth.
DECIM_W, 8, width of decimation factor.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
adc_data  in  DATA_W  unsigned ADC sample.
adc_valid  in  1  adc_data valid this cycle; no backpressure.
arm  in  1  start request; only honoured in IDLE.
abort  in  1  cancel any capture in progress.
level  in  DATA_W  unsigned trigger threshold.
decim  in  DECIM_W  keep 1 of every decim samples; 0 treated as 1.
signal_out  out  DATA_W  sample to store.
mem_valid  out  1  one-cycle write strobe for signal_out.
busy  out  1  high in ARMED or CAPTURE.
done  out  1  one-cycle pulse when DEPTH samples have been emitted.
state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.

Behaviour:
- Reset (asynchronous, any state, including mid-capture):
  - state=IDLE.
  - signal_out=0, mem_valid=0, busy=0, done=0.
  - All internal counters and registers cleared.
- IDLE:
  - arm=1 and abort=0 -> ARMED.
  - On that transition, latch decim and level. Changes to decim/level afterwards are ignored until the next arm.
  - Clear the decimation counter and the sample counter.
  - Mark the previous-sample register invalid.
  - If arm and abort are both high in IDLE, abort wins and the block stays in IDLE.
- Decimation:
  - Runs only in ARMED and CAPTURE.
  - dec_cnt advances only on adc_valid.
  - A sample is "kept" when adc_valid=1 and dec_cnt=0.
  - dec_cnt then counts up to max(decim,1)-1 and wraps to 0.
  - decim=0 or decim=1 keeps every valid sample.
- ARMED:
  - On each kept sample: if prev is valid, prev<level and sample>=level (unsigned), this is a trigger -> CAPTURE.
  - prev is updated with every kept sample and becomes valid after the first one. The first kept sample after arm can never trigger.
  - No mem_valid is produced in ARMED.
- CAPTURE:
  - The triggering sample is output sample 0.
  - Every kept sample, starting with the trigger sample, is registered to signal_out with mem_valid=1 on the next cycle. Latency is 1 clock from the adc_valid cycle.
  - mem_valid is a single-cycle pulse. signal_out holds its last value when mem_valid=0.
  - The sample counter (log2(DEPTH)+1 bits) increments per emitted sample.
  - When the emitted sample has count DEPTH-1, the next state is DONE.
  - Exactly DEPTH strobes are produced per capture, so the downstream address counter wraps back to 0 aligned to a capture boundary.
- DONE:
  - Lasts exactly one cycle with done=1 and busy=0, then goes to IDLE.
  - arm is ignored in DONE.
- abort:
  - In ARMED or CAPTURE -> IDLE on the next edge.
  - Any strobe that would have issued on that edge is suppressed.
  - No done pulse.
  - A partial capture is simply abandoned; the downstream RAM keeps whatever was written.
- arm while busy: ignored; it does not restart the capture.
- adc_valid gaps are allowed at any time; counters simply hold.
- busy=1 exactly when state is ARMED or CAPTURE.

Test Plan:
- Reset then arm, decim=1, level=512, ramp input 500,505,...,520 with adc_valid=1 each cycle -> trigger on 515 (prev 510<512). First mem_valid shows signal_out=515 one cycle after the 515 input, followed by 520, 525...
- Full capture with DEPTH overridden to 16, decim=3, continuous valid -> exactly 16 mem_valid pulses spaced 3 cycles apart, then done=1 for one cycle and state back to 0.
- First-sample guard: arm while input is already 600 (level 512) -> no trigger. Drop input to 100, then return to 600 -> trigger on 600.
- abort during CAPTURE after 5 strobes -> no further mem_valid, done stays 0, state=0 on the next cycle. Re-arm then captures normally.
- decim=0 with adc_valid toggling 1,0,1,0 -> one strobe per valid sample, each at 1-cycle latency.
- Assert rst_n low mid-capture -> all outputs 0 immediately (asynchronously). After release, the block is in IDLE and ignores further input until arm.

Source files
------------

// File: rtl/capture_trigger.sv
// Capture front-end: decimates the ADC stream, waits for a rising crossing of
// a latched level, then strobes exactly DEPTH samples to the RAM writer.
module capture_trigger #(
  parameter int DATA_W  = 10,
  parameter int DEPTH   = 65536,
  parameter int DECIM_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] level,
  input  logic [DECIM_W-1:0] decim,
  output logic [DATA_W-1:0] signal_out,
  output logic              mem_valid,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

  state_t             st_q, st_d;
  logic [DATA_W-1:0]  lvl_q, prev_q;
  logic               prev_vld;
  logic [DECIM_W-1:0] decim_q, dec_cnt, dec_max;
  logic [CNT_W-1:0]   cnt_q;
  logic               run, keep, trig, emit, last;

  always_comb begin
    run     = (st_q == ARMED) || (st_q == CAPTURE);
    dec_max = (decim_q == '0) ? '0 : decim_q - DECIM_W'(1);
    keep    = run && adc_valid && (dec_cnt == '0);
    trig    = keep && prev_vld && (prev_q < lvl_q) && (adc_data >= lvl_q);
    // the trigger sample itself is output sample 0
    emit    = !abort && (((st_q == ARMED) && trig) || ((st_q == CAPTURE) && keep));
    last    = (cnt_q == CNT_W'(DEPTH - 1));
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (arm && !abort) st_d = ARMED;
      ARMED:   if (abort) st_d = IDLE;
               else if (trig) st_d = last ? DONE : CAPTURE;
      CAPTURE: if (abort) st_d = IDLE;
               else if (emit && last) st_d = DONE;
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q      <= '0;
      decim_q    <= '0;
      dec_cnt    <= '0;
      prev_q     <= '0;
      prev_vld   <= 1'b0;
      cnt_q      <= '0;
      signal_out <= '0;
      mem_valid  <= 1'b0;
    end else begin
      mem_valid <= emit;
      if (emit) begin
        signal_out <= adc_data;
        cnt_q      <= cnt_q + CNT_W'(1);
      end
      if (st_q == IDLE && arm && !abort) begin
        lvl_q    <= level;
        decim_q  <= decim;
        dec_cnt  <= '0;
        cnt_q    <= '0;
        prev_vld <= 1'b0;
      end else if (run && adc_valid) begin
        dec_cnt <= (dec_cnt == dec_max) ? '0 : dec_cnt + DECIM_W'(1);
        if (keep) begin
          prev_q   <= adc_data;
          prev_vld <= 1'b1;
        end
      end
    end
  end

  assign busy  = (st_q == ARMED) || (st_q == CAPTURE);
  assign done  = (st_q == DONE);
  assign state = st_q;
endmodule

// File: tb/tb_capture_trigger.sv
// Directed bench for capture_trigger with DEPTH shrunk to 16.
module tb_capture_trigger;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] adc_data = '0;
  logic       adc_valid = 1'b0;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic [9:0] level = '0;
  logic [7:0] decim = '0;
  logic [9:0] signal_out;
  logic       mem_valid, busy, done;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  capture_trigger #(.DATA_W(10), .DEPTH(16), .DECIM_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .arm(arm), .abort(abort), .level(level), .decim(decim),
    .signal_out(signal_out), .mem_valid(mem_valid), .busy(busy),
    .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [7:0] d, input logic [9:0] l);
    arm = 1'b1; decim = d; level = l; adc_valid = 1'b0;
    tick();
    arm = 1'b0;
  endtask

  task automatic feed(input logic [9:0] v);
    adc_data = v; adc_valid = 1'b1;
    tick();
  endtask

  task automatic do_abort();
    abort = 1'b1; adc_valid = 1'b0;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({signal_out, mem_valid, busy, done, state} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_outputs got out=%0d mv=%0b busy=%0b done=%0b st=%0d want all 0",
               signal_out, mem_valid, busy, done, state);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ramp_trigger();
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    n_cmp++;
    if (state !== 2'd0) begin n_err++; $display("FAIL arm_abort_idle state got %0d want 0", state); end
    do_arm(8'd1, 10'd512);
    n_cmp++;
    if (state !== 2'd1 || busy !== 1'b1) begin
      n_err++; $display("FAIL armed_state got st=%0d busy=%0b want 1/1", state, busy);
    end
    feed(10'd500); feed(10'd505); feed(10'd510);
    n_cmp++;
    if (mem_valid !== 1'b0 || state !== 2'd1) begin
      n_err++; $display("FAIL ramp_pre_trig got mv=%0b st=%0d want 0/1", mem_valid, state);
    end
    feed(10'd515);
    n_cmp++;
    if (mem_valid !== 1'b1 || signal_out !== 10'd515 || state !== 2'd2) begin
      n_err++; $display("FAIL ramp_first got mv=%0b out=%0d st=%0d want 1/515/2", mem_valid, signal_out, state);
    end
    feed(10'd520);
    n_cmp++;
    if (mem_valid !== 1'b1 || signal_out !== 10'd520) begin
      n_err++; $display("FAIL ramp_second got mv=%0b out=%0d want 1/520", mem_valid, signal_out);
    end
    arm = 1'b1;
    feed(10'd525);
    arm = 1'b0;
    n_cmp++;
    if (mem_valid !== 1'b1 || signal_out !== 10'd525 || state !== 2'd2) begin
      n_err++; $display("FAIL arm_while_busy got mv=%0b out=%0d st=%0d want 1/525/2", mem_valid, signal_out, state);
    end
    do_abort();
  endtask

  task automatic test_full_capture();
    int nstb = 0, first = -1, lastc = -1, gap_err = 0, val_err = 0;
    int ndone = 0, done_i = -1, busy_err = 0;
    do_arm(8'd3, 10'd512);
    for (int i = 0; i < 80; i++) begin
      feed((i < 6) ? 10'd100 : 10'd700);
      if (mem_valid) begin
        if (nstb == 0) first = i;
        else if (i - lastc != 3) gap_err++;
        lastc = i;
        if (signal_out !== 10'd700) val_err++;
        nstb++;
      end
      if (done) begin
        ndone++; done_i = i;
        if (busy !== 1'b0) busy_err++;
      end
    end
    adc_valid = 1'b0;
    n_cmp++;
    if (nstb != 16) begin n_err++; $display("FAIL full_count got %0d want 16", nstb); end
    n_cmp++;
    if (first != 6 || gap_err != 0 || val_err != 0) begin
      n_err++; $display("FAIL full_spacing first=%0d gap_err=%0d val_err=%0d want 6/0/0", first, gap_err, val_err);
    end
    n_cmp++;
    if (ndone != 1 || done_i != 51 || busy_err != 0) begin
      n_err++; $display("FAIL full_done got n=%0d at=%0d busy_err=%0d want 1/51/0", ndone, done_i, busy_err);
    end
    n_cmp++;
    if (state !== 2'd0) begin n_err++; $display("FAIL full_end_state got %0d want 0", state); end
  endtask

  task automatic test_first_sample_guard();
    do_arm(8'd1, 10'd512);
    feed(10'd600); feed(10'd600); feed(10'd600);
    n_cmp++;
    if (mem_valid !== 1'b0 || state !== 2'd1) begin
      n_err++; $display("FAIL guard_no_trig got mv=%0b st=%0d want 0/1", mem_valid, state);
    end
    feed(10'd100);
    feed(10'd600);
    n_cmp++;
    if (mem_valid !== 1'b1 || signal_out !== 10'd600 || state !== 2'd2) begin
      n_err++; $display("FAIL guard_trig got mv=%0b out=%0d st=%0d want 1/600/2", mem_valid, signal_out, state);
    end
    do_abort();
  endtask

  task automatic test_abort();
    int nstb = 0, ndone = 0;
    do_arm(8'd1, 10'd512);
    feed(10'd100);
    for (int i = 0; i < 5; i++) begin
      feed(10'd600);
      if (mem_valid) nstb++;
    end
    n_cmp++;
    if (nstb != 5 || state !== 2'd2) begin
      n_err++; $display("FAIL abort_pre got strobes=%0d st=%0d want 5/2", nstb, state);
    end
    abort = 1'b1;
    feed(10'd600);
    abort = 1'b0;
    n_cmp++;
    if (mem_valid !== 1'b0 || done !== 1'b0 || state !== 2'd0) begin
      n_err++; $display("FAIL abort_edge got mv=%0b done=%0b st=%0d want 0/0/0", mem_valid, done, state);
    end
    nstb = 0;
    for (int i = 0; i < 3; i++) begin
      feed(10'd600);
      if (mem_valid || done) nstb++;
    end
    n_cmp++;
    if (nstb != 0) begin n_err++; $display("FAIL abort_after got events=%0d want 0", nstb); end
    do_arm(8'd1, 10'd512);
    feed(10'd100);
    nstb = 0;
    for (int i = 0; i < 20; i++) begin
      feed(10'd600);
      if (mem_valid) nstb++;
      if (done) ndone++;
    end
    adc_valid = 1'b0;
    n_cmp++;
    if (nstb != 16 || ndone != 1 || state !== 2'd0) begin
      n_err++; $display("FAIL rearm_capture got strobes=%0d done=%0d st=%0d want 16/1/0", nstb, ndone, state);
    end
  endtask

  task automatic test_decim0_gaps();
    do_arm(8'd0, 10'd512);
    feed(10'd511);
    feed(10'd512);
    n_cmp++;
    if (mem_valid !== 1'b1 || signal_out !== 10'd512) begin
      n_err++; $display("FAIL d0_equal_level got mv=%0b out=%0d want 1/512", mem_valid, signal_out);
    end
    adc_valid = 1'b0; tick();
    n_cmp++;
    if (mem_valid !== 1'b0 || signal_out !== 10'd512) begin
      n_err++; $display("FAIL d0_gap1 got mv=%0b out=%0d want 0/512", mem_valid, signal_out);
    end
    feed(10'd601);
    n_cmp++;
    if (mem_valid !== 1'b1 || signal_out !== 10'd601) begin
      n_err++; $display("FAIL d0_s1 got mv=%0b out=%0d want 1/601", mem_valid, signal_out);
    end
    adc_data = 10'd3; adc_valid = 1'b0; tick();
    n_cmp++;
    if (mem_valid !== 1'b0 || signal_out !== 10'd601) begin
      n_err++; $display("FAIL d0_gap2 got mv=%0b out=%0d want 0/601", mem_valid, signal_out);
    end
    feed(10'd602);
    n_cmp++;
    if (mem_valid !== 1'b1 || signal_out !== 10'd602) begin
      n_err++; $display("FAIL d0_s2 got mv=%0b out=%0d want 1/602", mem_valid, signal_out);
    end
    do_abort();
  endtask

  task automatic test_async_reset();
    int ev = 0;
    do_arm(8'd1, 10'd512);
    feed(10'd100); feed(10'd600); feed(10'd600);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({signal_out, mem_valid, busy, done, state} !== 15'd0) begin
      n_err++;
      $display("FAIL async_reset got out=%0d mv=%0b busy=%0b done=%0b st=%0d want all 0",
               signal_out, mem_valid, busy, done, state);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      feed((i % 2 == 0) ? 10'd100 : 10'd600);
      if (mem_valid || busy || state !== 2'd0) ev++;
    end
    adc_valid = 1'b0;
    n_cmp++;
    if (ev != 0) begin n_err++; $display("FAIL post_reset_idle got events=%0d want 0", ev); end
  endtask

  initial begin
    test_reset();
    test_ramp_trigger();
    test_full_capture();
    test_first_sample_guard();
    test_abort();
    test_decim0_gaps();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
